adam_axil_rr_arbiter: RTL and testbench



---
 rtl/adam_axil_rr_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_adam_axil_rr_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_axil_rr_arbiter.sv
// N-to-1 AXI-Lite arbiter with independent write (AW/W/B) and read (AR/R) paths.
// Define ADAM_AXIL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module adam_axil_rr_arbiter #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int NO_SLVS    = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                 seq_clk_i,
    input  logic                                 seq_rst_i,

    input  logic [NO_SLVS-1:0]                   slv_aw_valid_i,
    output logic [NO_SLVS-1:0]                   slv_aw_ready_o,
    input  logic [NO_SLVS-1:0][ADDR_WIDTH-1:0]   slv_aw_addr_i,
    input  logic [NO_SLVS-1:0][2:0]              slv_aw_prot_i,
    input  logic [NO_SLVS-1:0]                   slv_w_valid_i,
    output logic [NO_SLVS-1:0]                   slv_w_ready_o,
    input  logic [NO_SLVS-1:0][DATA_WIDTH-1:0]   slv_w_data_i,
    input  logic [NO_SLVS-1:0][STRB_WIDTH-1:0]   slv_w_strb_i,
    output logic [NO_SLVS-1:0]                   slv_b_valid_o,
    input  logic [NO_SLVS-1:0]                   slv_b_ready_i,
    output logic [NO_SLVS-1:0][1:0]              slv_b_resp_o,
    input  logic [NO_SLVS-1:0]                   slv_ar_valid_i,
    output logic [NO_SLVS-1:0]                   slv_ar_ready_o,
    input  logic [NO_SLVS-1:0][ADDR_WIDTH-1:0]   slv_ar_addr_i,
    input  logic [NO_SLVS-1:0][2:0]              slv_ar_prot_i,
    output logic [NO_SLVS-1:0]                   slv_r_valid_o,
    input  logic [NO_SLVS-1:0]                   slv_r_ready_i,
    output logic [NO_SLVS-1:0][DATA_WIDTH-1:0]   slv_r_data_o,
    output logic [NO_SLVS-1:0][1:0]              slv_r_resp_o,

    output logic                                 mst_aw_valid_o,
    input  logic                                 mst_aw_ready_i,
    output logic [ADDR_WIDTH-1:0]                mst_aw_addr_o,
    output logic [2:0]                           mst_aw_prot_o,
    output logic                                 mst_w_valid_o,
    input  logic                                 mst_w_ready_i,
    output logic [DATA_WIDTH-1:0]                mst_w_data_o,
    output logic [STRB_WIDTH-1:0]                mst_w_strb_o,
    input  logic                                 mst_b_valid_i,
    output logic                                 mst_b_ready_o,
    input  logic [1:0]                           mst_b_resp_i,
    output logic                                 mst_ar_valid_o,
    input  logic                                 mst_ar_ready_i,
    output logic [ADDR_WIDTH-1:0]                mst_ar_addr_o,
    output logic [2:0]                           mst_ar_prot_o,
    input  logic                                 mst_r_valid_i,
    output logic                                 mst_r_ready_o,
    input  logic [DATA_WIDTH-1:0]                mst_r_data_i,
    input  logic [1:0]                           mst_r_resp_i
);

    localparam int IDX_W = (NO_SLVS > 1) ? $clog2(NO_SLVS) : 1;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_e;

    w_state_e           w_state_q;
    r_state_e           r_state_q;
    logic [IDX_W-1:0]   wgnt_q, rgnt_q;
    logic               aw_done_q, w_done_q;
    logic [IDX_W-1:0]   w_pick, r_pick;
    logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef ADAM_AXIL_ARB_FIXED_PRIO_EN
    function automatic logic [IDX_W-1:0] pick(input logic [NO_SLVS-1:0] req);
        logic [IDX_W-1:0] sel;
        sel = '0;
        for (int i = NO_SLVS - 1; i >= 0; i--) begin
            if (req[IDX_W'(i)]) sel = IDX_W'(i);
        end
        return sel;
    endfunction

    assign w_pick = pick(slv_aw_valid_i);
    assign r_pick = pick(slv_ar_valid_i);
`else
    logic [IDX_W-1:0] wptr_q, rptr_q;

    // Descending scan so the smallest cyclic offset from ptr wins.
    function automatic logic [IDX_W-1:0] pick(input logic [NO_SLVS-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx;
        sel = '0;
        for (int k = NO_SLVS - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NO_SLVS);
            if (req[idx]) sel = idx;
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NO_SLVS - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    assign w_pick = pick(slv_aw_valid_i, wptr_q);
    assign r_pick = pick(slv_ar_valid_i, rptr_q);
`endif

    assign mst_aw_valid_o = (w_state_q == W_XFER) && !aw_done_q && slv_aw_valid_i[wgnt_q];
    assign mst_aw_addr_o  = slv_aw_addr_i[wgnt_q];
    assign mst_aw_prot_o  = slv_aw_prot_i[wgnt_q];
    assign mst_w_valid_o  = (w_state_q == W_XFER) && !w_done_q && slv_w_valid_i[wgnt_q];
    assign mst_w_data_o   = slv_w_data_i[wgnt_q];
    assign mst_w_strb_o   = slv_w_strb_i[wgnt_q];
    assign mst_b_ready_o  = (w_state_q == W_RESP) && slv_b_ready_i[wgnt_q];
    assign mst_ar_valid_o = (r_state_q == R_ADDR) && slv_ar_valid_i[rgnt_q];
    assign mst_ar_addr_o  = slv_ar_addr_i[rgnt_q];
    assign mst_ar_prot_o  = slv_ar_prot_i[rgnt_q];
    assign mst_r_ready_o  = (r_state_q == R_RESP) && slv_r_ready_i[rgnt_q];

    assign aw_hs = mst_aw_valid_o && mst_aw_ready_i;
    assign w_hs  = mst_w_valid_o  && mst_w_ready_i;
    assign b_hs  = mst_b_valid_i  && mst_b_ready_o;
    assign ar_hs = mst_ar_valid_o && mst_ar_ready_i;
    assign r_hs  = mst_r_valid_i  && mst_r_ready_o;

    always_comb begin
        slv_aw_ready_o = '0;
        slv_w_ready_o  = '0;
        slv_b_valid_o  = '0;
        slv_ar_ready_o = '0;
        slv_r_valid_o  = '0;
        slv_aw_ready_o[wgnt_q] = (w_state_q == W_XFER) && !aw_done_q && mst_aw_ready_i;
        slv_w_ready_o[wgnt_q]  = (w_state_q == W_XFER) && !w_done_q && mst_w_ready_i;
        slv_b_valid_o[wgnt_q]  = (w_state_q == W_RESP) && mst_b_valid_i;
        slv_ar_ready_o[rgnt_q] = (r_state_q == R_ADDR) && mst_ar_ready_i;
        slv_r_valid_o[rgnt_q]  = (r_state_q == R_RESP) && mst_r_valid_i;
        for (int i = 0; i < NO_SLVS; i++) begin
            slv_b_resp_o[i] = mst_b_resp_i;
            slv_r_resp_o[i] = mst_r_resp_i;
            slv_r_data_o[i] = mst_r_data_i;
        end
    end

    always_ff @(posedge seq_clk_i) begin
        if (seq_rst_i) begin
            w_state_q <= W_IDLE;
            wgnt_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef ADAM_AXIL_ARB_FIXED_PRIO_EN
            wptr_q    <= '0;
`endif
        end else begin
            case (w_state_q)
                W_IDLE: if (|slv_aw_valid_i) begin
                    wgnt_q    <= w_pick;
                    w_state_q <= W_XFER;
                end
                W_XFER: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) w_state_q <= W_RESP;
                end
                W_RESP: if (b_hs) begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    w_state_q <= W_IDLE;
`ifndef ADAM_AXIL_ARB_FIXED_PRIO_EN
                    wptr_q    <= nxt(wgnt_q);
`endif
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge seq_clk_i) begin
        if (seq_rst_i) begin
            r_state_q <= R_IDLE;
            rgnt_q    <= '0;
`ifndef ADAM_AXIL_ARB_FIXED_PRIO_EN
            rptr_q    <= '0;
`endif
        end else begin
            case (r_state_q)
                R_IDLE: if (|slv_ar_valid_i) begin
                    rgnt_q    <= r_pick;
                    r_state_q <= R_ADDR;
                end
                R_ADDR: if (ar_hs) r_state_q <= R_RESP;
                R_RESP: if (r_hs) begin
                    r_state_q <= R_IDLE;
`ifndef ADAM_AXIL_ARB_FIXED_PRIO_EN
                    rptr_q    <= nxt(rgnt_q);
`endif
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adam_axil_rr_arbiter.sv
// Directed bench for adam_axil_rr_arbiter (4 requesters, 32-bit address/data).
module tb_adam_axil_rr_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic [3:0]        s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr;
    logic [3:0][31:0]  s_awa, s_wd, s_ara, s_rd;
    logic [3:0][2:0]   s_awp, s_arp;
    logic [3:0][3:0]   s_ws;
    logic [3:0][1:0]   s_bresp, s_rresp;

    logic        m_awv, m_awr, m_wv, m_wr, m_bv, m_br, m_arv, m_arr, m_rv, m_rr;
    logic [31:0] m_awa, m_wd, m_ara, m_rd;
    logic [2:0]  m_awp, m_arp;
    logic [3:0]  m_ws;
    logic [1:0]  m_bresp, m_rresp;

    int total;
    int bad;

    adam_axil_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_SLVS(4)) dut (
        .seq_clk_i(clk), .seq_rst_i(rst),
        .slv_aw_valid_i(s_awv), .slv_aw_ready_o(s_awr), .slv_aw_addr_i(s_awa), .slv_aw_prot_i(s_awp),
        .slv_w_valid_i(s_wv), .slv_w_ready_o(s_wr), .slv_w_data_i(s_wd), .slv_w_strb_i(s_ws),
        .slv_b_valid_o(s_bv), .slv_b_ready_i(s_br), .slv_b_resp_o(s_bresp),
        .slv_ar_valid_i(s_arv), .slv_ar_ready_o(s_arr), .slv_ar_addr_i(s_ara), .slv_ar_prot_i(s_arp),
        .slv_r_valid_o(s_rv), .slv_r_ready_i(s_rr), .slv_r_data_o(s_rd), .slv_r_resp_o(s_rresp),
        .mst_aw_valid_o(m_awv), .mst_aw_ready_i(m_awr), .mst_aw_addr_o(m_awa), .mst_aw_prot_o(m_awp),
        .mst_w_valid_o(m_wv), .mst_w_ready_i(m_wr), .mst_w_data_o(m_wd), .mst_w_strb_o(m_ws),
        .mst_b_valid_i(m_bv), .mst_b_ready_o(m_br), .mst_b_resp_i(m_bresp),
        .mst_ar_valid_o(m_arv), .mst_ar_ready_i(m_arr), .mst_ar_addr_o(m_ara), .mst_ar_prot_o(m_arp),
        .mst_r_valid_i(m_rv), .mst_r_ready_o(m_rr), .mst_r_data_i(m_rd), .mst_r_resp_i(m_rresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] p;
    logic [5:0] ord;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        s_awv = '0; s_wv = '0; s_arv = '0; s_br = '1; s_rr = '1;
        s_awa = '0; s_wd = '0; s_ara = '0; s_awp = '0; s_arp = '0; s_ws = '0;
        m_awr = 1'b0; m_wr = 1'b0; m_bv = 1'b0; m_arr = 1'b0; m_rv = 1'b0;
        m_bresp = '0; m_rresp = '0; m_rd = '0;
        tick(); tick();

        chk("rst_m_awv", 64'(m_awv), 64'd0);
        chk("rst_m_wv",  64'(m_wv),  64'd0);
        chk("rst_m_arv", 64'(m_arv), 64'd0);
        chk("rst_m_br",  64'(m_br),  64'd0);
        chk("rst_m_rr",  64'(m_rr),  64'd0);
        chk("rst_s_rdy", 64'(s_awr | s_wr | s_arr), 64'd0);
        chk("rst_s_vld", 64'(s_bv | s_rv), 64'd0);
        rst = 1'b0;
        tick();

        // single write then read from slv[2]
        s_awv[2] = 1'b1; s_awa[2] = 32'h1000_0040; s_awp[2] = 3'd5;
        s_wv[2] = 1'b1; s_wd[2] = 32'hDEAD_BEEF; s_ws[2] = 4'hF;
        m_awr = 1'b1; m_wr = 1'b1;
        #1;
        chk("t1_arb_cycle", 64'(m_awv), 64'd0);
        tick();
        chk("t1_awv",   64'(m_awv), 64'd1);
        chk("t1_awa",   64'(m_awa), 64'h1000_0040);
        chk("t1_awp",   64'(m_awp), 64'd5);
        chk("t1_wv",    64'(m_wv),  64'd1);
        chk("t1_wd",    64'(m_wd),  64'hDEAD_BEEF);
        chk("t1_ws",    64'(m_ws),  64'hF);
        chk("t1_s_awr", 64'(s_awr), 64'b0100);
        chk("t1_s_wr",  64'(s_wr),  64'b0100);
        chk("t1_br_xfer", 64'(m_br), 64'd0);
        tick();
        s_awv = '0; s_wv = '0; m_bv = 1'b1; m_bresp = 2'b00;
        #1;
        chk("t1_awv_resp", 64'(m_awv), 64'd0);
        chk("t1_br",    64'(m_br), 64'd1);
        chk("t1_s_bv",  64'(s_bv), 64'b0100);
        chk("t1_bresp", 64'(s_bresp[2]), 64'd0);
        tick();
        m_bv = 1'b0;
        #1;
        chk("t1_br_idle", 64'(m_br), 64'd0);
        s_arv[2] = 1'b1; s_ara[2] = 32'h1000_0040; m_arr = 1'b1;
        #1;
        chk("t1_ar_arb", 64'(m_arv), 64'd0);
        tick();
        chk("t1_arv",   64'(m_arv), 64'd1);
        chk("t1_ara",   64'(m_ara), 64'h1000_0040);
        chk("t1_s_arr", 64'(s_arr), 64'b0100);
        chk("t1_rr_addr", 64'(m_rr), 64'd0);
        tick();
        s_arv = '0; m_rv = 1'b1; m_rd = 32'hDEAD_BEEF; m_rresp = 2'b00;
        #1;
        chk("t1_rr",    64'(m_rr), 64'd1);
        chk("t1_s_rv",  64'(s_rv), 64'b0100);
        chk("t1_rdata", 64'(s_rd[2]), 64'hDEAD_BEEF);
        chk("t1_others_awv", 64'(m_awv), 64'd0);
        tick();
        m_rv = 1'b0;
        #1;
        chk("t1_rr_idle", 64'(m_rr), 64'd0);

        // contention of all four ports right after reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        s_awa = {32'h300, 32'h200, 32'h100, 32'h000};
        s_wd  = {32'd3, 32'd2, 32'd1, 32'd0};
        s_awv = 4'hF; s_wv = 4'hF; m_awr = 1'b1; m_wr = 1'b1;
        #1;
        p = 2'd0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_idle", 64'(m_awv), 64'd0);
            tick();
            chk("t2_order", 64'(m_awa), 64'(p) << 8);
            chk("t2_s_awr", 64'(s_awr), 64'(4'b0001 << p));
            chk("t2_wd",    64'(m_wd),  64'(p));
            tick();
            s_awv[p] = 1'b0; s_wv[p] = 1'b0; m_bv = 1'b1; m_bresp = p;
            #1;
            chk("t2_s_bv",  64'(s_bv), 64'(4'b0001 << p));
            chk("t2_bresp", 64'(s_bresp[p]), 64'(p));
            tick();
            m_bv = 1'b0;
            #1;
            p = p + 2'd1;
        end

        s_awv = 4'b1010; s_wv = 4'b1010;
        #1;
        ord = {2'd0, 2'd3, 2'd1};
        for (int j = 0; j < 2; j++) begin
            p = ord[1:0];
            ord = ord >> 2;
            tick();
            chk("t2b_s_awr", 64'(s_awr), 64'(4'b0001 << p));
            chk("t2b_awa",   64'(m_awa), 64'(p) << 8);
            tick();
            s_awv[p] = 1'b0; s_wv[p] = 1'b0; m_bv = 1'b1;
            #1;
            chk("t2b_s_bv", 64'(s_bv), 64'(4'b0001 << p));
            tick();
            m_bv = 1'b0;
            #1;
        end

        // W presented 3 cycles before AW on slv[1]
        s_wv[1] = 1'b1; s_wd[1] = 32'hA5A5_0001; s_ws[1] = 4'h3;
        m_awr = 1'b0; m_wr = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_w_held", 64'(m_wv), 64'd0);
            chk("t3_s_wr",   64'(s_wr), 64'd0);
            tick();
        end
        s_awv[1] = 1'b1; s_awa[1] = 32'h2000_0000;
        #1;
        chk("t3_arb", 64'(m_awv), 64'd0);
        tick();
        chk("t3_wv",    64'(m_wv),  64'd1);
        chk("t3_wd",    64'(m_wd),  64'hA5A5_0001);
        chk("t3_awv",   64'(m_awv), 64'd1);
        chk("t3_s_wr",  64'(s_wr),  64'b0010);
        chk("t3_s_awr0", 64'(s_awr), 64'd0);
        tick();
        s_wv[1] = 1'b0;
        #1;
        chk("t3_wv_forced", 64'(m_wv), 64'd0);
        chk("t3_awv_still", 64'(m_awv), 64'd1);
        chk("t3_br_xfer",   64'(m_br), 64'd0);
        chk("t3_s_wr_done", 64'(s_wr), 64'd0);
        m_awr = 1'b1;
        #1;
        chk("t3_s_awr", 64'(s_awr), 64'b0010);
        tick();
        s_awv[1] = 1'b0; m_bv = 1'b1; m_bresp = 2'b10;
        #1;
        chk("t3_br",    64'(m_br), 64'd1);
        chk("t3_s_bv",  64'(s_bv), 64'b0010);
        chk("t3_bresp", 64'(s_bresp[1]), 64'd2);
        tick();
        chk("t3_one_b", 64'(s_bv), 64'd0);
        chk("t3_br_idle", 64'(m_br), 64'd0);
        m_bv = 1'b0;

        // concurrent write from slv[0] and read from slv[3]
        s_awv[0] = 1'b1; s_awa[0] = 32'h3000_0000; s_wv[0] = 1'b1;
        s_arv[3] = 1'b1; s_ara[3] = 32'h4000_0010;
        m_awr = 1'b1; m_wr = 1'b1; m_arr = 1'b1;
        #1;
        tick();
        chk("t4_awv",   64'(m_awv), 64'd1);
        chk("t4_arv",   64'(m_arv), 64'd1);
        chk("t4_ara",   64'(m_ara), 64'h4000_0010);
        chk("t4_s_awr", 64'(s_awr), 64'b0001);
        chk("t4_s_arr", 64'(s_arr), 64'b1000);
        chk("t4_br0",   64'(m_br), 64'd0);
        chk("t4_rr0",   64'(m_rr), 64'd0);
        tick();
        s_awv = '0; s_wv = '0; s_arv = '0;
        #1;
        chk("t4_br1", 64'(m_br), 64'd1);
        chk("t4_rr1", 64'(m_rr), 64'd1);
        m_bv = 1'b1; m_bresp = 2'b00;
        #1;
        chk("t4_s_bv", 64'(s_bv), 64'b0001);
        chk("t4_s_rv0", 64'(s_rv), 64'd0);
        tick();
        m_bv = 1'b0; m_rv = 1'b1; m_rd = 32'h1234_5678; m_rresp = 2'b01;
        #1;
        chk("t4_br_idle", 64'(m_br), 64'd0);
        chk("t4_rr_hold", 64'(m_rr), 64'd1);
        chk("t4_s_rv",    64'(s_rv), 64'b1000);
        chk("t4_rdata",   64'(s_rd[3]), 64'h1234_5678);
        chk("t4_rresp",   64'(s_rresp[3]), 64'd1);
        tick();
        m_rv = 1'b0;
        #1;
        chk("t4_rr_idle", 64'(m_rr), 64'd0);

        // downstream stall with a second requester waiting
        s_awv[1] = 1'b1; s_awa[1] = 32'h5000_0000; s_wv[1] = 1'b1;
        s_awv[2] = 1'b1; s_awa[2] = 32'h6000_0000; s_wv[2] = 1'b1;
        m_awr = 1'b0; m_wr = 1'b0;
        #1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t5_awv_stall", 64'(m_awv), 64'd1);
            chk("t5_gnt_fixed", 64'(m_awa), 64'h5000_0000);
            chk("t5_no_rdy",    64'(s_awr | s_wr), 64'd0);
            tick();
        end
        m_awr = 1'b1; m_wr = 1'b1;
        #1;
        chk("t5_s_awr", 64'(s_awr), 64'b0010);
        chk("t5_s_wr",  64'(s_wr),  64'b0010);
        tick();
        s_awv[1] = 1'b0; s_wv[1] = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t5_wait_rdy", 64'(s_awr | s_wr), 64'd0);
            chk("t5_wait_awv", 64'(m_awv), 64'd0);
            chk("t5_wait_br",  64'(m_br), 64'd1);
            tick();
        end
        m_bv = 1'b1;
        #1;
        chk("t5_s_bv1", 64'(s_bv), 64'b0010);
        tick();
        m_bv = 1'b0;
        #1;
        chk("t5_idle_rdy", 64'(s_awr), 64'd0);
        tick();
        chk("t5_s_awr2", 64'(s_awr), 64'b0100);
        chk("t5_awa2",   64'(m_awa), 64'h6000_0000);
        tick();
        s_awv[2] = 1'b0; s_wv[2] = 1'b0; m_bv = 1'b1;
        #1;
        chk("t5_s_bv2", 64'(s_bv), 64'b0100);
        tick();
        m_bv = 1'b0;
        #1;

        // reset after AW handshake, before W
        s_awv[0] = 1'b1; s_awa[0] = 32'h7000_0000; s_wv[0] = 1'b1;
        m_awr = 1'b1; m_wr = 1'b0;
        #1;
        tick();
        chk("t6_awv", 64'(m_awv), 64'd1);
        tick();
        s_awv[0] = 1'b0;
        #1;
        chk("t6_aw_forced", 64'(m_awv), 64'd0);
        chk("t6_wv",        64'(m_wv),  64'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_wv",  64'(m_wv), 64'd0);
        chk("t6_rst_awv", 64'(m_awv), 64'd0);
        chk("t6_rst_br",  64'(m_br), 64'd0);
        chk("t6_rst_rdy", 64'(s_awr | s_wr | s_arr), 64'd0);
        tick();
        rst = 1'b0; s_awv[0] = 1'b1; m_wr = 1'b1;
        #1;
        chk("t6_arb", 64'(m_awv), 64'd0);
        tick();
        chk("t6_awv2",  64'(m_awv), 64'd1);
        chk("t6_wv2",   64'(m_wv),  64'd1);
        chk("t6_s_awr", 64'(s_awr), 64'b0001);
        chk("t6_s_wr",  64'(s_wr),  64'b0001);
        tick();
        s_awv[0] = 1'b0; s_wv[0] = 1'b0; m_bv = 1'b1;
        #1;
        chk("t6_s_bv", 64'(s_bv), 64'b0001);
        tick();
        m_bv = 1'b0;
        #1;

        // repeated contention of slv[0] and slv[2]; both keep requesting
        s_awa[0] = 32'h8000_0000; s_awa[2] = 32'h9000_0000;
        s_awv = 4'b0101; s_wv = 4'b0101;
        #1;
`ifdef ADAM_AXIL_ARB_FIXED_PRIO_EN
        ord = {2'd0, 2'd0, 2'd0};
`else
        ord = {2'd2, 2'd0, 2'd2};
`endif
        for (int j = 0; j < 3; j++) begin
            p = ord[1:0];
            ord = ord >> 2;
            tick();
            chk("t7_gnt", 64'(s_awr), 64'(4'b0001 << p));
            tick();
            m_bv = 1'b1;
            #1;
            chk("t7_s_bv", 64'(s_bv), 64'(4'b0001 << p));
            tick();
            m_bv = 1'b0;
            #1;
        end
        s_awv = '0; s_wv = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
